frame_stack: RTL and testbench
==============================

# frame_stack

- Parametrised successor to the single-limit operand stack; serves as the WebAssembly operand-and-locals stack in the core.
- Holds a frame-limit stack internally, so call entry/return no longer needs an external `underflow_limit` register.
- Adds frame-relative local GET/SET with bounds checking and optional DUP/SWAP.
- One op is accepted per clock; results are registered.

## Interface
- `WIDTH`, 32, data word width.
- `DEPTH`, 4, log2 of operand capacity (`CAP` = 2^DEPTH entries).
- `FRAMES_DEPTH`, 2, log2 of maximum nested frames (`FCAP` = 2^FRAMES_DEPTH).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears state immediately.
- `op`  in  4  operation code.
- `data`  in  WIDTH  push/replace/set value.
- `offset`  in  DEPTH+1  local index (GET/SET) or argument count (FRAME_ENTER).
- `index`  out  DEPTH+1  number of stored entries.
- `limit`  out  DEPTH+1  current frame base (entries below it are protected).
- `frame_count`  out  FRAMES_DEPTH+1  number of open frames.
- `out`  out  WIDTH  registered top of stack.
- `status`  out  3  registered result code.

## Operation

Op codes:
- 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 DUP, 5 SWAP, 6 GET, 7 SET.
- 8 FRAME_ENTER, 9 FRAME_LEAVE, 10 FRAME_LEAVE_PUSH.
- 11–15 act as NOP.

Status codes:
- 0 NONE, 1 EMPTY, 2 FULL, 3 OVERFLOW, 4 UNDERFLOW, 5 FRAME_OVERFLOW, 6 FRAME_UNDERFLOW, 7 BAD_OFFSET.

Frame size is `index - limit`. Op behaviour:
- **PUSH**: OVERFLOW if `index == CAP`; else `mem[index] <= data`, index+1.
- **POP**: UNDERFLOW if size 0; else index-1.
- **REPLACE**: UNDERFLOW if size 0; else `mem[index-1] <= data`.
- **DUP**: UNDERFLOW if size 0; else OVERFLOW if full; else push `mem[index-1]`.
- **SWAP**: UNDERFLOW if size < 2; else exchange the top two entries.
- **GET**: `addr = limit + offset`, computed at DEPTH+2 bits (no wrap). BAD_OFFSET if `addr >= index`; else OVERFLOW if full; else push `mem[addr]`.
- **SET**: BAD_OFFSET if `addr >= index`; else `mem[addr] <= data`; index unchanged.
- **FRAME_ENTER**:
  - FRAME_OVERFLOW if `frame_count == FCAP`; else UNDERFLOW if `offset > size`.
  - Otherwise save the old limit to the frame array, set `limit <= index - offset` (the arguments become locals 0..offset-1), frame_count+1.
- **FRAME_LEAVE**: FRAME_UNDERFLOW if `frame_count == 0`; else `index <= limit`, limit restored from the frame array, frame_count-1.
- **FRAME_LEAVE_PUSH**:
  - Same checks as FRAME_LEAVE, plus OVERFLOW if `limit == CAP`.
  - Otherwise leave, then `mem[old limit] <= data`, `index <= old limit + 1`.

Error and update rules:
- Any error aborts the whole op. index, limit, frame_count, mem and out are unchanged. Status shows the error code for one cycle.
- On a successful op, status is derived from the post-op state, first match wins:
  - EMPTY if size 0 (including `limit == CAP`);
  - FULL if `index == CAP`;
  - otherwise NONE.
- NOP recomputes status from the current state, so a stale error clears.
- `out` takes `mem[new index - 1]` (including the written value on the same edge) when new index > 0. Otherwise it holds.
- `out` may show caller data when size is 0. Consumers must qualify `out` with `status`.

## Timing
- Reset values:
  - `index`, `limit`, `frame_count` = 0;
  - `out` = 0;
  - `status` = EMPTY.
- Memory and frame arrays are not cleared by reset.
- Reset asserted mid-cycle clears state at once, with no clock needed. The first edge after release executes the op then presented.
- Latency is 1 cycle: an op sampled at edge N is reflected on all outputs after edge N.
- No handshake. Back-to-back ops are fully supported.
- Storage is a register array with combinational read and one write port per cycle. SWAP uses two writes on the same edge to distinct addresses.

## Configuration
- `FRAME_STACK_DUP_SWAP_EN` defined: DUP and SWAP behave as specified above.
- Undefined: op codes 4 and 5 decode as NOP, and their logic is not synthesised.

## Test plan
Bench parameters: WIDTH=8, DEPTH=2, FRAMES_DEPTH=1.
1. Reset low then high.
   - Expect status EMPTY, index 0, out 00.
   - POP → UNDERFLOW, index 0; following NOP → EMPTY.
2. PUSH 01, 02, 03, 04.
   - Expect status NONE, NONE, NONE, FULL; out 04; index 4.
   - PUSH 05 → OVERFLOW, index 4, out 04.
3. From reset: PUSH 0A, PUSH 0B, FRAME_ENTER offset=1.
   - Expect limit 1, frame_count 1, NONE.
   - GET 0 → out 0B, index 3.
   - SET offset=1 data=0C → out 0C.
   - GET 2 → BAD_OFFSET, index 3.
   - FRAME_LEAVE_PUSH 0D → index 2, limit 0, frame_count 0, out 0D, NONE.
4. Two FRAME_ENTER offset=0.
   - Expect frame_count 2, limit 0.
   - Third FRAME_ENTER → FRAME_OVERFLOW.
   - Two FRAME_LEAVE, then a third → FRAME_UNDERFLOW, frame_count 0.
5. PUSH 01, PUSH 02, SWAP.
   - With macro: out 01; POP → out 02; DUP → out 02, index 2.
   - Without macro: SWAP → NONE, out 02.
6. Pull reset low between edges mid-sequence.
   - Expect index, limit, frame_count 0 and status EMPTY before the next edge.

Source files
------------

// File: rtl/frame_stack.sv
// frame_stack: operand-and-locals stack with an internal frame-limit stack.
// One op per clock, registered results. Frame-relative local GET/SET with
// bounds checking; FRAME_ENTER/LEAVE/LEAVE_PUSH manage call frames.
// Optional feature macro: FRAME_STACK_DUP_SWAP_EN enables DUP (op 4) and
// SWAP (op 5); when undefined those op codes decode as NOP.
module frame_stack #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FRAMES_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              op,
  input  logic [WIDTH-1:0]        data,
  input  logic [DEPTH:0]          offset,
  output logic [DEPTH:0]          index,
  output logic [DEPTH:0]          limit,
  output logic [FRAMES_DEPTH:0]   frame_count,
  output logic [WIDTH-1:0]        out,
  output logic [2:0]              status
);

  localparam int unsigned CAP  = 1 << DEPTH;
  localparam int unsigned FCAP = 1 << FRAMES_DEPTH;
  localparam int unsigned IW   = DEPTH + 1;
  localparam int unsigned AW   = DEPTH + 2;
  localparam int unsigned FW   = FRAMES_DEPTH + 1;

  localparam logic [IW-1:0] CAP_I  = IW'(CAP);
  localparam logic [FW-1:0] FCAP_F = FW'(FCAP);

  typedef enum logic [3:0] {
    OP_NOP         = 4'd0,
    OP_PUSH        = 4'd1,
    OP_POP         = 4'd2,
    OP_REPLACE     = 4'd3,
    OP_DUP         = 4'd4,
    OP_SWAP        = 4'd5,
    OP_GET         = 4'd6,
    OP_SET         = 4'd7,
    OP_FRAME_ENTER = 4'd8,
    OP_FRAME_LEAVE = 4'd9,
    OP_FRAME_LPUSH = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    ST_NONE            = 3'd0,
    ST_EMPTY           = 3'd1,
    ST_FULL            = 3'd2,
    ST_OVERFLOW        = 3'd3,
    ST_UNDERFLOW       = 3'd4,
    ST_FRAME_OVERFLOW  = 3'd5,
    ST_FRAME_UNDERFLOW = 3'd6,
    ST_BAD_OFFSET      = 3'd7
  } status_e;

  // Storage: operand array and saved frame limits (not reset)
  logic [WIDTH-1:0] mem    [CAP];
  logic [IW-1:0]    frames [FCAP];

  // Current-state derived values
  logic [IW-1:0]        size;
  logic [DEPTH-1:0]     top_addr;
  logic [AW-1:0]        get_addr;
  logic [FRAMES_DEPTH-1:0] fr_top;
  logic [FRAMES_DEPTH-1:0] fr_next;
  logic                 is_full;
`ifdef FRAME_STACK_DUP_SWAP_EN
  logic [DEPTH-1:0]     sub_addr;
`endif

  // Next-state values
  logic [IW-1:0]    index_n;
  logic [IW-1:0]    limit_n;
  logic [FW-1:0]    fcnt_n;
  logic [WIDTH-1:0] out_n;
  logic [2:0]       status_n;
  logic             err;
  logic [2:0]       err_code;
  logic [DEPTH-1:0] new_top;

  // Write ports: port 0 for all writes, port 1 only for SWAP
  logic             wr0_en;
  logic [DEPTH-1:0] wr0_addr;
  logic [WIDTH-1:0] wr0_data;
  logic             wr1_en;
  logic [DEPTH-1:0] wr1_addr;
  logic [WIDTH-1:0] wr1_data;
  logic             fr_en;
  logic [FRAMES_DEPTH-1:0] fr_addr;
  logic [IW-1:0]    fr_data;

  // Address and size helpers from the current registered state
  always_comb begin
    size     = index - limit;
    top_addr = DEPTH'(index - IW'(1));
    get_addr = AW'(limit) + AW'(offset);
    fr_top   = FRAMES_DEPTH'(frame_count - FW'(1));
    fr_next  = FRAMES_DEPTH'(frame_count);
    is_full  = (index == CAP_I);
`ifdef FRAME_STACK_DUP_SWAP_EN
    sub_addr = DEPTH'(index - IW'(2));
`endif
  end

  // Op decode: error checks, next pointers and write requests
  always_comb begin
    index_n  = index;
    limit_n  = limit;
    fcnt_n   = frame_count;
    err      = 1'b0;
    err_code = ST_NONE;
    wr0_en   = 1'b0;
    wr0_addr = '0;
    wr0_data = '0;
    wr1_en   = 1'b0;
    wr1_addr = '0;
    wr1_data = '0;
    fr_en    = 1'b0;
    fr_addr  = '0;
    fr_data  = '0;

    case (op)
      OP_PUSH: begin
        if (is_full) begin
          err      = 1'b1;
          err_code = ST_OVERFLOW;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = DEPTH'(index);
          wr0_data = data;
          index_n  = index + IW'(1);
        end
      end
      OP_POP: begin
        if (size == '0) begin
          err      = 1'b1;
          err_code = ST_UNDERFLOW;
        end else begin
          index_n = index - IW'(1);
        end
      end
      OP_REPLACE: begin
        if (size == '0) begin
          err      = 1'b1;
          err_code = ST_UNDERFLOW;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = top_addr;
          wr0_data = data;
        end
      end
`ifdef FRAME_STACK_DUP_SWAP_EN
      OP_DUP: begin
        if (size == '0) begin
          err      = 1'b1;
          err_code = ST_UNDERFLOW;
        end else if (is_full) begin
          err      = 1'b1;
          err_code = ST_OVERFLOW;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = DEPTH'(index);
          wr0_data = mem[top_addr];
          index_n  = index + IW'(1);
        end
      end
      OP_SWAP: begin
        if (size < IW'(2)) begin
          err      = 1'b1;
          err_code = ST_UNDERFLOW;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = top_addr;
          wr0_data = mem[sub_addr];
          wr1_en   = 1'b1;
          wr1_addr = sub_addr;
          wr1_data = mem[top_addr];
        end
      end
`endif
      OP_GET: begin
        if (get_addr >= AW'(index)) begin
          err      = 1'b1;
          err_code = ST_BAD_OFFSET;
        end else if (is_full) begin
          err      = 1'b1;
          err_code = ST_OVERFLOW;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = DEPTH'(index);
          wr0_data = mem[DEPTH'(get_addr)];
          index_n  = index + IW'(1);
        end
      end
      OP_SET: begin
        if (get_addr >= AW'(index)) begin
          err      = 1'b1;
          err_code = ST_BAD_OFFSET;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = DEPTH'(get_addr);
          wr0_data = data;
        end
      end
      OP_FRAME_ENTER: begin
        if (frame_count == FCAP_F) begin
          err      = 1'b1;
          err_code = ST_FRAME_OVERFLOW;
        end else if (offset > size) begin
          err      = 1'b1;
          err_code = ST_UNDERFLOW;
        end else begin
          fr_en   = 1'b1;
          fr_addr = fr_next;
          fr_data = limit;
          limit_n = index - offset;
          fcnt_n  = frame_count + FW'(1);
        end
      end
      OP_FRAME_LEAVE: begin
        if (frame_count == '0) begin
          err      = 1'b1;
          err_code = ST_FRAME_UNDERFLOW;
        end else begin
          index_n = limit;
          limit_n = frames[fr_top];
          fcnt_n  = frame_count - FW'(1);
        end
      end
      OP_FRAME_LPUSH: begin
        if (frame_count == '0) begin
          err      = 1'b1;
          err_code = ST_FRAME_UNDERFLOW;
        end else if (limit == CAP_I) begin
          err      = 1'b1;
          err_code = ST_OVERFLOW;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = DEPTH'(limit);
          wr0_data = data;
          index_n  = limit + IW'(1);
          limit_n  = frames[fr_top];
          fcnt_n   = frame_count - FW'(1);
        end
      end
      default: begin
        // NOP and unassigned codes: state unchanged, status recomputed
      end
    endcase
  end

  // Post-op status and top-of-stack value, forwarding same-edge writes
  always_comb begin
    status_n = ST_NONE;
    out_n    = out;
    new_top  = DEPTH'(index_n - IW'(1));
    if (err) begin
      status_n = err_code;
    end else begin
      if (index_n == limit_n) begin
        status_n = ST_EMPTY;
      end else if (index_n == CAP_I) begin
        status_n = ST_FULL;
      end else begin
        status_n = ST_NONE;
      end
      if (index_n != '0) begin
        if (wr0_en && (wr0_addr == new_top)) begin
          out_n = wr0_data;
        end else if (wr1_en && (wr1_addr == new_top)) begin
          out_n = wr1_data;
        end else begin
          out_n = mem[new_top];
        end
      end
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index       <= '0;
      limit       <= '0;
      frame_count <= '0;
      out         <= '0;
      status      <= ST_EMPTY;
    end else begin
      index       <= index_n;
      limit       <= limit_n;
      frame_count <= fcnt_n;
      out         <= out_n;
      status      <= status_n;
    end
  end

  // Storage writes; suppressed while reset is held
  always_ff @(posedge clk) begin
    if (reset && wr0_en) begin
      mem[wr0_addr] <= wr0_data;
    end
    if (reset && wr1_en) begin
      mem[wr1_addr] <= wr1_data;
    end
    if (reset && fr_en) begin
      frames[fr_addr] <= fr_data;
    end
  end

endmodule

// File: tb/tb_frame_stack.sv
// Self-checking bench for frame_stack (WIDTH=8, DEPTH=2, FRAMES_DEPTH=1).
// Reference model keeps the stack as a queue and frame bases as a queue.
module tb_frame_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int FRAMES_DEPTH = 1;
  localparam int CAP  = 4;
  localparam int FCAP = 2;

  localparam int S_NONE = 0, S_EMPTY = 1, S_FULL = 2, S_OVF = 3, S_UNF = 4,
                 S_FOVF = 5, S_FUNF = 6, S_BAD = 7;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [3:0]            op = 4'd0;
  logic [WIDTH-1:0]      data = '0;
  logic [DEPTH:0]        offset = '0;
  logic [DEPTH:0]        index;
  logic [DEPTH:0]        limit;
  logic [FRAMES_DEPTH:0] frame_count;
  logic [WIDTH-1:0]      out;
  logic [2:0]            status;

  frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES_DEPTH(FRAMES_DEPTH)) dut (
    .clk(clk), .reset(reset), .op(op), .data(data), .offset(offset),
    .index(index), .limit(limit), .frame_count(frame_count),
    .out(out), .status(status)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] stk[$];
  int         frames[$];
  int         lim;
  logic [7:0] m_out;
  int         m_status;

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    frames.delete();
    lim = 0;
    m_out = 8'h00;
    m_status = S_EMPTY;
  endtask

  task automatic model_step(input int o, input logic [7:0] d, input int off);
    int n, sz, e, a;
    logic [7:0] t;
    n  = stk.size();
    sz = n - lim;
    e  = -1;
    case (o)
      1: if (n == CAP) e = S_OVF; else stk.push_back(d);
      2: if (sz == 0) e = S_UNF; else void'(stk.pop_back());
      3: if (sz == 0) e = S_UNF; else stk[n-1] = d;
`ifdef FRAME_STACK_DUP_SWAP_EN
      4: if (sz == 0) e = S_UNF; else if (n == CAP) e = S_OVF; else begin
           t = stk[n-1]; stk.push_back(t);
         end
      5: if (sz < 2) e = S_UNF; else begin
           t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t;
         end
`endif
      6: begin
           a = lim + off;
           if (a >= n) e = S_BAD; else if (n == CAP) e = S_OVF;
           else begin t = stk[a]; stk.push_back(t); end
         end
      7: begin
           a = lim + off;
           if (a >= n) e = S_BAD; else stk[a] = d;
         end
      8: if (frames.size() == FCAP) e = S_FOVF; else if (off > sz) e = S_UNF;
         else begin frames.push_back(lim); lim = n - off; end
      9: if (frames.size() == 0) e = S_FUNF; else begin
           while (stk.size() > lim) void'(stk.pop_back());
           lim = frames.pop_back();
         end
      10: if (frames.size() == 0) e = S_FUNF; else if (lim == CAP) e = S_OVF;
          else begin
            while (stk.size() > lim) void'(stk.pop_back());
            stk.push_back(d);
            lim = frames.pop_back();
          end
      default: ;
    endcase
    if (e >= 0) begin
      m_status = e;
    end else begin
      if (stk.size() == lim) m_status = S_EMPTY;
      else if (stk.size() == CAP) m_status = S_FULL;
      else m_status = S_NONE;
      if (stk.size() > 0) m_out = stk[stk.size()-1];
    end
  endtask

  task automatic check_all();
    chk("index", 32'(index), 32'(stk.size()));
    chk("limit", 32'(limit), 32'(lim));
    chk("frame_count", 32'(frame_count), 32'(frames.size()));
    chk("out", 32'(out), 32'(m_out));
    chk("status", 32'(status), 32'(m_status));
  endtask

  // Present one op, clock it, and compare everything against the model
  task automatic do_op(input int o, input logic [7:0] d, input int off);
    op     = 4'(o);
    data   = d;
    offset = 3'(off);
    @(posedge clk);
    #1;
    step++;
    model_step(o, d, off);
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    reset = 1'b0;
    #3;
    model_reset();
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    int o, off;
    logic [7:0] d;

    #1;
    // 1: reset, then POP underflow and NOP recovery
    do_reset();
    chk("rst_status", 32'(status), S_EMPTY);
    chk("rst_out", 32'(out), 32'h00);
    do_op(2, 8'h00, 0);
    chk("pop_empty", 32'(status), S_UNF);
    do_op(0, 8'h00, 0);
    chk("nop_clears", 32'(status), S_EMPTY);

    // 2: fill to capacity and overflow
    do_op(1, 8'h01, 0);
    do_op(1, 8'h02, 0);
    do_op(1, 8'h03, 0);
    do_op(1, 8'h04, 0);
    chk("fill_status", 32'(status), S_FULL);
    do_op(1, 8'h05, 0);
    chk("push_ovf", 32'(status), S_OVF);
    chk("push_ovf_out", 32'(out), 32'h04);

    // 3: frame with one argument, locals access, leave-with-result
    do_reset();
    do_op(1, 8'h0A, 0);
    do_op(1, 8'h0B, 0);
    do_op(8, 8'h00, 1);
    chk("enter_limit", 32'(limit), 1);
    do_op(6, 8'h00, 0);
    chk("get0_out", 32'(out), 32'h0B);
    do_op(7, 8'h0C, 1);
    chk("set1_out", 32'(out), 32'h0C);
    do_op(6, 8'h00, 2);
    chk("get2_bad", 32'(status), S_BAD);
    do_op(10, 8'h0D, 0);
    chk("lpush_out", 32'(out), 32'h0D);
    chk("lpush_index", 32'(index), 2);

    // 4: frame nesting limits
    do_reset();
    do_op(8, 8'h00, 0);
    do_op(8, 8'h00, 0);
    chk("nest_fc", 32'(frame_count), 2);
    do_op(8, 8'h00, 0);
    chk("nest_fovf", 32'(status), S_FOVF);
    do_op(9, 8'h00, 0);
    do_op(9, 8'h00, 0);
    do_op(9, 8'h00, 0);
    chk("leave_funf", 32'(status), S_FUNF);

    // 5: SWAP / DUP (or NOP when the feature is compiled out)
    do_reset();
    do_op(1, 8'h01, 0);
    do_op(1, 8'h02, 0);
    do_op(5, 8'h00, 0);
`ifdef FRAME_STACK_DUP_SWAP_EN
    chk("swap_out", 32'(out), 32'h01);
    do_op(2, 8'h00, 0);
    chk("pop_after_swap", 32'(out), 32'h02);
    do_op(4, 8'h00, 0);
    chk("dup_out", 32'(out), 32'h02);
    chk("dup_index", 32'(index), 2);
`else
    chk("swap_nop_status", 32'(status), S_NONE);
    chk("swap_nop_out", 32'(out), 32'h02);
`endif

    // 6: mid-sequence asynchronous reset, then continue
    do_op(8, 8'h00, 1);
    do_reset();
    chk("midrst_limit", 32'(limit), 0);

    // Randomized ops against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) o = 1;
      else o = int'($urandom_range(0, 15));
      d   = 8'($urandom);
      off = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) off = int'($urandom_range(0, 2));
      do_op(o, d, off);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
